// File: rtl/div_lrtl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_lrtl -- sequential restoring divider (companion of the 4x4 multiplier)
//
// Divides a DW-bit dividend by a VW-bit divisor, producing one quotient bit
// per clock, MSB first. A start/done handshake carries operands in and the
// quotient/remainder out. Dividing by zero finishes after a single cycle with
// an all-ones quotient, the low dividend bits as remainder, and the dz flag.
//
// Parameters:
//   DW  dividend / quotient width (>= 2)
//   VW  divisor / remainder width (1 <= VW <= DW)
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   request, sampled only while not busy
//   a      in   DW  dividend, captured on an accepted start
//   b      in   VW  divisor, captured on an accepted start
//   busy   out  1   high while a division is iterating
//   done   out  1   one-cycle pulse, q/r/dz valid
//   q      out  DW  quotient, held until the result of the next operation
//   r      out  VW  remainder, held likewise
//   dz     out  1   divide-by-zero flag, held with q/r
//   err    out  1   (only with DIV_LRTL_CHECK_EN) round-trip check failure
//
// Build option:
//   DIV_LRTL_CHECK_EN  adds the err output, which in the done cycle flags
//                      q*b + r != a for non-zero divisors.
// -----------------------------------------------------------------------------
module div_lrtl #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          dz
`ifdef DIV_LRTL_CHECK_EN
  ,
  output logic          err
`endif
);

  // Counter only has to hold DW-1.
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e        state_q, state_d;
  // Dividend shift register; quotient bits enter at the LSB as dividend bits
  // leave at the MSB, so after DW steps it holds the quotient.
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  // Stored partial remainder is always < divisor, so VW bits are enough;
  // only the shifted trial value needs the extra bit.
  logic [VW-1:0] pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [VW:0]   pr_shift;
  logic [VW-1:0] pr_sub;
  logic          qbit;

`ifdef DIV_LRTL_CHECK_EN
  logic [DW-1:0]    a_q, a_d;
  logic [DW+VW-1:0] chk_prod;
  logic [DW+VW-1:0] chk_sum;
`endif

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= {DW{1'b0}};
      dvs_q   <= {VW{1'b0}};
      pr_q    <= {VW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      q_q     <= {DW{1'b0}};
      r_q     <= {VW{1'b0}};
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_LRTL_CHECK_EN
      a_q     <= {DW{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_LRTL_CHECK_EN
      a_q     <= a_d;
`endif
    end
  end

  // Next-state, iteration step and result capture.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
`ifdef DIV_LRTL_CHECK_EN
    a_d     = a_q;
`endif

    // One restoring step: bring down the next dividend bit and try to
    // subtract. The subtraction result is < divisor, so it fits VW bits.
    pr_shift = {pr_q, dvd_q[DW-1]};
    pr_sub   = pr_shift[VW-1:0] - dvs_q;
    qbit     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvs_d = b;
`ifdef DIV_LRTL_CHECK_EN
          a_d   = a;
`endif
          if (b != {VW{1'b0}}) begin
            state_d = S_RUN;
            dvd_d   = a;
            pr_d    = {VW{1'b0}};
            cnt_d   = CW'(DW - 1);
          end else begin
            // Divide by zero: skip iteration, report immediately.
            state_d = S_DONE;
            q_d     = {DW{1'b1}};
            r_d     = a[VW-1:0];
            dz_d    = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (pr_shift >= {1'b0, dvs_q}) begin
          pr_d = pr_sub;
          qbit = 1'b1;
        end else begin
          pr_d = pr_shift[VW-1:0];
          qbit = 1'b0;
        end
        dvd_d = {dvd_q[DW-2:0], qbit};

        if (cnt_q != {CW{1'b0}}) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Last step: publish the freshly completed quotient/remainder.
          state_d = S_DONE;
          q_d     = dvd_d;
          r_d     = pr_d;
          dz_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

`ifdef DIV_LRTL_CHECK_EN
  // Round-trip check on the registered result: a == q*b + r.
  always_comb begin
    chk_prod = (DW+VW)'(q_q) * (DW+VW)'(dvs_q);
    chk_sum  = chk_prod + (DW+VW)'(r_q);
    if (done_q && !dz_q) begin
      err = (chk_sum != (DW+VW)'(a_q));
    end else begin
      err = 1'b0;
    end
  end
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule

// File: doc/div_lrtl.md
Name: div_lrtl

Overview:
- Sequential restoring divider; the inverse of the 4x4 array multiplier.
- Divides a DW-bit dividend by a VW-bit divisor, one quotient bit per clock.
- Returns quotient and remainder through a start/done handshake.
- Sits beside the multiplier in the arithmetic sample set; also serves as its round-trip checker (a = q*b + r).

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width; must be <= DW.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request; sampled only when busy=0.
- a, input, DW, dividend; captured on accepted start.
- b, input, VW, divisor; captured on accepted start.
- busy, output, 1, high while a division is in progress.
- done, output, 1, one-cycle pulse marking q/r/dz valid.
- q, output, DW, quotient; held until next accepted start.
- r, output, VW, remainder; held until next accepted start.
- dz, output, 1, divide-by-zero flag; valid with done, held with q/r.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, q=0, r=0, dz=0; internal registers cleared.
  - Reset overrides every other input in that cycle.
- States:
  - IDLE (busy=0, done=0).
  - RUN (busy=1).
  - DONE (busy=0, done=1, exactly one cycle).
- Transitions:
  - IDLE/DONE, start=1, b!=0 -> RUN. Latch a and b, clear the partial remainder, load the iteration counter with DW-1.
  - IDLE/DONE, start=1, b==0 -> DONE on the next edge with dz=1, q={DW{1'b1}}, r=a[VW-1:0]. Latency 1 cycle.
  - IDLE/DONE, start=0 -> IDLE.
  - RUN, counter!=0 -> RUN, counter decrements.
  - RUN, counter==0 -> DONE.
- Iteration (each RUN edge, MSB first):
  - pr' = {pr[VW-1:0], dividend_msb}; pr is VW+1 bits wide.
  - If pr' >= {1'b0,b}: pr = pr' - b and the quotient bit is 1. Otherwise pr = pr' and the bit is 0.
  - The dividend shift register shifts left by one.
- Output update: q and r update only on the edge that enters DONE. r = pr[VW-1:0], dz=0.
- Latency: start accepted at edge T -> done high in the cycle following edge T+DW (8 cycles for the defaults). busy is high for exactly DW cycles.
- Handshake:
  - start while busy=1 is ignored; no queuing, latched operands unchanged.
  - start in the DONE cycle is accepted (back-to-back). q/r/dz still show the previous result during that cycle.
  - a and b are don't-care except in the accepting cycle.
- Ranges: for b>=1, q <= a always fits DW bits and r < b always fits VW bits. No overflow flag is needed.
- Reset mid-RUN: abort the operation. No done pulse follows; outputs read 0.

Optional Feature:
- Macro: DIV_LRTL_CHECK_EN.
- Defined:
  - Adds output port err (1 bit).
  - In the DONE cycle, err = (q*b + r != a) && !dz, using a combinational DW+VW-bit product of the registered outputs.
  - err is 0 in all other cycles and 0 on reset.
- Undefined: port err and its check logic are absent; the remaining behaviour is identical.

Test Plan:
- a=100, b=7, start pulse -> busy for 8 cycles, done pulse, q=14, r=2, dz=0; err=0 if the macro is defined.
- a=255, b=15, then a=5, b=9 issued on the first done cycle -> q=17, r=0; then 8 cycles later q=0, r=5 (back-to-back accept).
- a=0x3C, b=0 -> done one cycle after start, dz=1, q=0xFF, r=0xC, busy never asserted.
- a=200, b=3 started; in cycle 3 of RUN assert start with a=1, b=1 -> ignored; result q=66, r=2.
- a=77, b=5 started; rst_n=0 on RUN cycle 4 -> next cycle busy=0, done=0, q=0, r=0; no done pulse within 16 cycles.
- Exhaustive sweep: all a in 0..255, b in 1..15 -> q=a/b, r=a%b against the model. With the macro defined, err stays 0 throughout.
